// File: rtl/hdmi_tx_stream.sv
// hdmi_tx_stream
//   Video output stage feeding the MS7210 HDMI transmitter. Everything runs in
//   the clk_pixel domain. The block:
//   - delays RGB/DE/HS/VS through a fixed PIPE_STAGES-deep register pipeline
//     and re-encodes sync polarity;
//   - measures input timing and tracks lock with a small FSM;
//   - can replace pixel data with colour bars or a solid colour.
//   It only forwards input timing and never generates timing of its own.
//
// Ports
//   clk_pixel    in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   rgb          in   {R,G,B} pixel data, COLOR_W bits per channel
//   de, hs, vs   in   input timing; HS/VS active level set by *_POL_IN
//   mode         in   00 pass, 01 colour bars, 10 solid, 11 auto
//                     (sampled only at frame start)
//   solid_rgb    in   fill colour for solid mode and for auto while unlocked
//   rgb_out      out  pixel data, PIPE_STAGES cycles after rgb
//   de_out       out  de, PIPE_STAGES cycles after de
//   hs_out       out  hs, delayed the same way; active level HS_POL_OUT
//   vs_out       out  vs, delayed the same way; active level VS_POL_OUT
//   tmds_clk_p   out  forwarded clk_pixel
//   locked       out  input timing matches H_ACTIVE x V_ACTIVE
//   h_meas       out  active pixels in the last completed line
//   v_meas       out  active lines in the last completed frame
//   frame_cnt    out  input frames seen (wraps)
//   lock_state   out  debug view of the lock FSM
//                     (0 UNLOCKED, 1 CHECK, 2 LOCKED)
//
// There is no valid/ready handshake. de qualifies pixel data on every cycle,
// and nothing can stall the pipeline.
module hdmi_tx_stream #(
  parameter int COLOR_W      = 8,
  parameter int H_ACTIVE     = 1920,
  parameter int V_ACTIVE     = 1080,
  parameter int PIPE_STAGES  = 2,
  parameter int HS_POL_IN    = 1,
  parameter int VS_POL_IN    = 1,
  parameter int HS_POL_OUT   = 1,
  parameter int VS_POL_OUT   = 1,
  parameter int LOSS_TIMEOUT = 2_000_000
) (
  input  logic                 clk_pixel,
  input  logic                 rst_n,
  input  logic [3*COLOR_W-1:0] rgb,
  input  logic                 de,
  input  logic                 hs,
  input  logic                 vs,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [3*COLOR_W-1:0] rgb_out,
  output logic                 de_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 tmds_clk_p,
  output logic                 locked,
  output logic [15:0]          h_meas,
  output logic [15:0]          v_meas,
  output logic [15:0]          frame_cnt,
  output logic [1:0]           lock_state
);

  localparam int PW    = 3 * COLOR_W + 3;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int WD_W  = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LOSS_TIMEOUT);

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_BARS  = 2'b01;
  localparam logic [1:0] MODE_SOLID = 2'b10;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  lock_state_t state, state_nxt;

  // Work internally with active-high syncs.
  logic hs_i, vs_i;
  assign hs_i = hs ~^ HS_POL_IN[0];
  assign vs_i = vs ~^ VS_POL_IN[0];

  logic de_d, vs_d;
  logic de_rise, de_fall, frame_start;
  assign de_rise     = de & ~de_d;
  assign de_fall     = ~de & de_d;
  assign frame_start = vs_i & ~vs_d;

  logic [15:0]     pix_cnt, line_pix, line_cnt;
  logic            frame_eval;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            good_frame;
  logic [1:0]      active_mode;
  logic [15:0]     bar_pos;
  logic [2:0]      bar_idx;

  // A frame start in the same cycle masks the expiry.
  assign wd_expire  = (wd_cnt == WD_MAX) && !frame_start;
  assign good_frame = (h_meas == 16'(H_ACTIVE)) && (v_meas == 16'(V_ACTIVE));

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      de_d        <= 1'b0;
      vs_d        <= 1'b0;
      pix_cnt     <= '0;
      line_pix    <= '0;
      line_cnt    <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
      frame_cnt   <= '0;
      frame_eval  <= 1'b0;
      wd_cnt      <= '0;
      active_mode <= MODE_PASS;
      bar_pos     <= '0;
      bar_idx     <= '0;
    end else begin
      de_d       <= de;
      vs_d       <= vs_i;
      frame_eval <= frame_start;

      if (de_fall) begin
        line_pix <= pix_cnt;
        pix_cnt  <= '0;
      end else if (de && pix_cnt != 16'hFFFF) begin
        pix_cnt <= pix_cnt + 16'd1;
      end

      if (frame_start) begin
        // If a line ends in this same cycle, its count is not in line_pix yet.
        // Take it straight from the pixel counter.
        h_meas      <= de_fall ? pix_cnt : line_pix;
        v_meas      <= line_cnt;
        line_cnt    <= de_rise ? 16'd1 : 16'd0;
        frame_cnt   <= frame_cnt + 16'd1;
        active_mode <= mode;
      end else if (de_rise && line_cnt != 16'hFFFF) begin
        line_cnt <= line_cnt + 16'd1;
      end

      if (frame_start)          wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;

      // The x position is split into bar index and offset within the bar.
      // The index stops at 7, which also covers lines longer than H_ACTIVE.
      if (!de) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == 16'(BAR_W - 1)) begin
        bar_pos <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 16'd1;
      end
    end
  end

  // Lock FSM. The frame is judged one cycle after frame start, once
  // h_meas and v_meas hold the captured values.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) state <= ST_UNLOCKED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wd_expire) begin
      state_nxt = ST_UNLOCKED;
    end else if (frame_eval) begin
      case (state)
        ST_UNLOCKED: if (good_frame) state_nxt = ST_CHECK;
        ST_CHECK:    state_nxt = good_frame ? ST_LOCKED : ST_UNLOCKED;
        ST_LOCKED:   if (!good_frame) state_nxt = ST_UNLOCKED;
        default:     state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  assign locked     = (state == ST_LOCKED);
  assign lock_state = state;

  // Pixel source selection. Bar colours, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  // In bar-index terms that is R = ~idx[1], G = ~idx[2], B = ~idx[0].
  logic [3*COLOR_W-1:0] pix_src;
  always_comb begin
    pix_src = rgb;
    case (active_mode)
      MODE_PASS:  pix_src = rgb;
      MODE_BARS:  pix_src = {{COLOR_W{~bar_idx[1]}},
                             {COLOR_W{~bar_idx[2]}},
                             {COLOR_W{~bar_idx[0]}}};
      MODE_SOLID: pix_src = solid_rgb;
      default:    pix_src = locked ? rgb : solid_rgb;
    endcase
    if (!de) pix_src = '0;
  end

  // Data, de and syncs share one pipeline, so their alignment cannot drift
  // in any mode.
  logic [PW-1:0] pipe_q [PIPE_STAGES];

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {pix_src, de, hs_i, vs_i};
      for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  logic hs_act_q, vs_act_q;
  assign {rgb_out, de_out, hs_act_q, vs_act_q} = pipe_q[PIPE_STAGES-1];
  // Re-encode to the output polarity. Internal 0 maps to the inactive level.
  assign hs_out     = hs_act_q ^ ~HS_POL_OUT[0];
  assign vs_out     = vs_act_q ^ ~VS_POL_OUT[0];
  assign tmds_clk_p = clk_pixel;

endmodule
